// File: rtl/round_key_sequencer_if.sv
// round_key_sequencer_if: key-bundle load, stream request and round-key handshake bus.
interface round_key_sequencer_if;
  logic [1407:0] round_keys_in;
  logic          key_load;
  logic          start;
  logic          decrypt;
  logic          key_ready;
  logic          busy;
  logic          rk_valid;
  logic          rk_ready;
  logic [127:0]  rk_data;
  logic [3:0]    rk_index;
  logic          rk_last;
  modport master (
    output round_keys_in, key_load, start, decrypt, rk_ready,
    input  key_ready, busy, rk_valid, rk_data, rk_index, rk_last
  );
  modport slave (
    input  round_keys_in, key_load, start, decrypt, rk_ready,
    output key_ready, busy, rk_valid, rk_data, rk_index, rk_last
  );
endinterface

// File: rtl/round_key_sequencer.sv
// round_key_sequencer: buffers an 11-key schedule bundle and streams one round key per handshake,
// forward (0..10) for encryption or reverse (10..0) for decryption.
module round_key_sequencer (
  input logic                    clk,
  input logic                    rst,
  round_key_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {EMPTY, LOADED, STREAM} state_t;
  state_t       r_state;
  logic [127:0] r_slot [11];
  logic [3:0]   r_ptr;
  logic         r_dir;
  logic         w_valid;
  logic         w_term;
  assign w_valid = r_state == STREAM;
  assign w_term  = r_ptr == (r_dir ? 4'd0 : 4'd10);
  // Load beats start; the bundle is frozen while a stream is running.
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_dir   <= 1'b0;
      for (int k = 0; k < 11; k++) r_slot[k] <= '0;
    end else if (r_state != STREAM && bus.key_load) begin
      for (int k = 0; k < 11; k++) r_slot[k] <= bus.round_keys_in[128*k +: 128];
      r_state <= LOADED;
    end else if (r_state == LOADED && bus.start) begin
      r_dir   <= bus.decrypt;
      r_ptr   <= bus.decrypt ? 4'd10 : 4'd0;
      r_state <= STREAM;
    end else if (w_valid && bus.rk_ready) begin
      if (w_term) r_state <= LOADED;
      else r_ptr <= r_dir ? r_ptr - 4'd1 : r_ptr + 4'd1;
    end
  assign bus.key_ready = r_state != EMPTY;
  assign bus.busy      = w_valid;
  assign bus.rk_valid  = w_valid;
  assign bus.rk_data   = w_valid ? r_slot[r_ptr] : '0;
  assign bus.rk_index  = w_valid ? r_ptr : 4'd0;
  assign bus.rk_last   = w_valid & w_term;
endmodule

// File: tb/tb_round_key_sequencer.sv
// tb_round_key_sequencer: directed test-plan steps plus random traffic, checked every cycle
// against a queue-based model of the key stream.
module tb_round_key_sequencer;
  logic clk = 1'b0;
  logic rst;
  round_key_sequencer_if bus ();
  round_key_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [127:0] m_keys [11];
  logic         m_has;
  int           m_q [$];
  logic [1407:0] fips, alt;
  logic [127:0] fips_keys [11];
  int cnt, c4, h;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs sampled at the edge, then compare all outputs.
  task automatic step();
    logic streaming;
    @(posedge clk);
    streaming = m_q.size() > 0;
    if (rst) begin
      m_has = 1'b0;
      m_q.delete();
      foreach (m_keys[k]) m_keys[k] = '0;
    end else if (!streaming && bus.key_load) begin
      foreach (m_keys[k]) m_keys[k] = bus.round_keys_in[128*k +: 128];
      m_has = 1'b1;
    end else if (m_has && bus.start && !streaming) begin
      for (int k = 0; k < 11; k++) m_q.push_back(bus.decrypt ? 10 - k : k);
    end else if (streaming && bus.rk_ready) begin
      void'(m_q.pop_front());
    end
    #1;
    chk("key_ready", bus.key_ready, m_has);
    chk("busy", bus.busy, m_q.size() > 0);
    chk("rk_valid", bus.rk_valid, m_q.size() > 0);
    chk("rk_index", bus.rk_index, m_q.size() > 0 ? m_q[0] : 0);
    chk("rk_data", bus.rk_data, m_q.size() > 0 ? m_keys[m_q[0]] : 128'd0);
    chk("rk_last", bus.rk_last, m_q.size() == 1);
  endtask

  task automatic idle();
    rst = 1'b0; bus.key_load = 1'b0; bus.start = 1'b0; bus.decrypt = 1'b0; bus.rk_ready = 1'b1;
  endtask

  initial begin
    fips_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int k = 0; k < 11; k++) fips[128*k +: 128] = fips_keys[k];
    for (int w = 0; w < 44; w++) alt[32*w +: 32] = $urandom;
    m_has = 1'b0;
    foreach (m_keys[k]) m_keys[k] = '0;
    idle();
    bus.round_keys_in = fips;
    rst = 1'b1;
    step();
    step();
    chk("reset_key_ready", bus.key_ready, 1'b0);
    chk("reset_rk_data", bus.rk_data, 128'd0);
    idle();
    // start while EMPTY is ignored
    bus.start = 1'b1; step(); idle(); step();
    chk("empty_start_valid", bus.rk_valid, 1'b0);
    // forward FIPS stream
    bus.key_load = 1'b1; step(); idle();
    bus.start = 1'b1; step(); idle();
    chk("fwd_first_data", bus.rk_data, fips_keys[0]);
    cnt = 0;
    for (int n = 0; n < 20 && bus.rk_valid; n++) begin
      chk("fwd_order", bus.rk_index, cnt);
      chk("fwd_last_only_10", bus.rk_last, cnt == 10);
      if (bus.rk_index == 4'd10) chk("fwd_key10", bus.rk_data, fips_keys[10]);
      cnt++;
      step();
    end
    chk("fwd_count", cnt, 11);
    // reverse stream
    bus.start = 1'b1; bus.decrypt = 1'b1; step(); idle();
    chk("rev_first_index", bus.rk_index, 4'd10);
    chk("rev_first_data", bus.rk_data, fips_keys[10]);
    cnt = 0;
    for (int n = 0; n < 20 && bus.rk_valid; n++) begin
      if (bus.rk_last) chk("rev_last_data", bus.rk_data, fips_keys[0]);
      cnt++;
      step();
    end
    chk("rev_count", cnt, 11);
    chk("rev_busy_after", bus.busy, 1'b0);
    // back-pressure at index 4 for 3 cycles
    bus.start = 1'b1; step(); idle();
    cnt = 0; c4 = 0; h = 0;
    for (int n = 0; n < 30 && bus.rk_valid; n++) begin
      bus.rk_ready = 1'b1;
      if (bus.rk_index == 4'd4) begin
        c4++;
        chk("bp_hold_data", bus.rk_data, fips_keys[4]);
        if (h < 3) begin bus.rk_ready = 1'b0; h++; end
      end
      cnt++;
      step();
    end
    idle();
    chk("bp_cycles", cnt, 14);
    chk("bp_idx4_cycles", c4, 4);
    // load and start mid-stream are ignored
    bus.start = 1'b1; step(); idle();
    for (int n = 0; n < 5; n++) step();
    bus.key_load = 1'b1; bus.start = 1'b1; bus.round_keys_in = alt; step(); idle();
    for (int n = 0; n < 20 && bus.rk_valid; n++) begin
      chk("ign_key_ready", bus.key_ready, 1'b1);
      chk("ign_orig_keys", bus.rk_data, fips_keys[bus.rk_index]);
      step();
    end
    chk("ign_done", bus.rk_valid, 1'b0);
    // load/start collision: load wins
    bus.key_load = 1'b1; bus.start = 1'b1; step(); idle();
    chk("coll_no_stream", bus.rk_valid, 1'b0);
    bus.start = 1'b1; step(); idle();
    chk("coll_new_key0", bus.rk_data, alt[127:0]);
    for (int n = 0; n < 20 && bus.rk_valid; n++) step();
    // reset mid-stream at index 6
    bus.round_keys_in = fips; bus.key_load = 1'b1; step(); idle();
    bus.start = 1'b1; step(); idle();
    for (int n = 0; n < 20 && bus.rk_index != 4'd6; n++) step();
    chk("rst_at_idx6", bus.rk_index, 4'd6);
    rst = 1'b1; step(); idle();
    chk("rst_mid_valid", bus.rk_valid, 1'b0);
    chk("rst_mid_key_ready", bus.key_ready, 1'b0);
    chk("rst_mid_data", bus.rk_data, 128'd0);
    bus.start = 1'b1; step(); idle();
    chk("rst_start_ignored", bus.rk_valid, 1'b0);
    bus.key_load = 1'b1; step(); idle();
    bus.start = 1'b1; step(); idle();
    chk("rst_reload_stream", bus.rk_data, fips_keys[0]);
    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(63) == 0;
      bus.key_load = $urandom_range(7) == 0;
      bus.start = $urandom_range(3) == 0;
      bus.decrypt = $urandom_range(1);
      bus.rk_ready = $urandom_range(3) != 0;
      if (bus.key_load) for (int w = 0; w < 44; w++) bus.round_keys_in[32*w +: 32] = $urandom;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
